seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised multiplexed seven-segment scanner driving DIGITS common-cathode/anode digits from a BCD value, with run-time segment and common polarity. Adds tear-free double-buffered loading, an anti-ghosting guard interval per digit, dash/blank glyphs and a frame-done pulse. It sits between the dice/result logic and the pads: segments on `uo_out`, commons on `uio_out` with `uio_oe`.

## Interface
- `DIGITS`, default 2: number of multiplexed digits, legal range 1..8.
- `PRESCALE`, default 1000: clock cycles per digit slot; must satisfy PRESCALE > BLANK_CYCLES.
- `BLANK_CYCLES`, default 16: guard cycles at the start of each slot, with all commons inactive.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `enable_i` in 1: scan enable. Low means idle with commons tristated.
- `value_i` in 4*DIGITS: BCD nibbles. Nibble 0 is the rightmost digit.
- `dp_i` in DIGITS: decimal point per digit.
- `load_i` in 1: captures `value_i`/`dp_i` into the pending buffer.
- `seg_pol_i` in 1: 1 means segments are active high.
- `com_pol_i` in 1: 1 means commons are active high.
- `seg_o` out 8: {dp,g,f,e,d,c,b,a}, polarity applied.
- `com_o` out DIGITS: one-hot active common, polarity applied.
- `com_oe_o` out DIGITS: output enables for the commons.
- `frame_done_o` out 1: one-cycle pulse at each frame boundary.

## Operation
- States:
  - IDLE: `enable_i` is low.
  - GUARD: slot counter < BLANK_CYCLES.
  - SHOW: the remainder of the slot.
- State transitions:
  - IDLE→GUARD on `enable_i`=1, starting at digit 0 with slot counter 0.
  - GUARD→SHOW when slot counter = BLANK_CYCLES-1.
  - SHOW→GUARD when slot counter = PRESCALE-1. The digit index increments at this point and wraps from DIGITS-1 to 0.
  - Any state→IDLE on `enable_i`=0. This clears the slot counter and the digit index.
- Glyph decode (segment codes, {dp,g..a} with dp=0):
  - 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66
  - 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F
  - 10..14→0x40 (dash), 15→0x00 (blank)
  - dp bit 7 = `dp_i` of that digit
- Outputs by state (internal active-high segments/commons):
  - SHOW: segments = glyph of the current digit; common = one-hot at the current index.
  - GUARD and IDLE: segments and commons all 0.
- Output polarity:
  - `seg_o` = internal segments XOR {8{~seg_pol_i}}.
  - `com_o` = internal commons XOR {DIGITS{~com_pol_i}}.
- Common output enables: `com_oe_o` is all-ones unless in IDLE, where it is 0.
- Buffering:
  - `load_i` writes the pending register.
  - The display register copies pending at the frame boundary, i.e. the SHOW→GUARD transition with index DIGITS-1.
  - If `load_i` coincides with the boundary, `value_i` goes straight to the display register and to pending.
- Reset:
  - State IDLE, counters 0.
  - Pending and display registers all nibbles 0xF (blank), `dp` 0.
  - `frame_done_o`=0, `com_oe_o`=0, `seg_o`/`com_o` at the inactive level for the current polarity inputs.

## Timing
- All state, counters and internal segment/common values are registered. Polarity XOR is the only output combinational logic; the polarity inputs are quasi-static.
- `enable_i` rising in cycle N:
  - GUARD is visible in N+1.
  - The first SHOW cycle is N+1+BLANK_CYCLES.
- Slot length is exactly PRESCALE cycles. Frame length is DIGITS*PRESCALE cycles.
- `frame_done_o` is high in the first GUARD cycle of digit 0 of each new frame. It does not pulse on the first frame after IDLE.
- `enable_i` falling: IDLE outputs appear the next cycle.
- `rst` mid-frame: all reset values appear the next cycle, and the pending value is lost.
- DIGITS=1: index stays 0, and every slot end is a frame boundary.

## Configuration
- `SEG_SCAN_LZB_EN` defined:
  - Leading-zero blanking on the display register, scanning from digit DIGITS-1 down.
  - Each 0 nibble is shown as 0x00 until the first nonzero nibble.
  - Digit 0 is never blanked.
  - dp is still shown on a blanked digit.
- `SEG_SCAN_LZB_EN` undefined: zeros are always shown as 0x3F.

## Structure
- Package `seg_scan_pkg` holds:
  - the state enum {IDLE, GUARD, SHOW};
  - the glyph constants (SEG_DASH=0x40, SEG_BLANK=0x00, the digit table);
  - the `bcd_to_seg` function.
- Sub-module `seg7_decode`: combinational nibble+dp → 8-bit glyph, instantiated once on the selected digit.
- Top level holds the counters, state machine, buffers and LZB logic.

## Test plan
All scenarios use DIGITS=2, PRESCALE=8, BLANK_CYCLES=2, polarities=1.
- Reset, `enable_i`=1, no load → GUARD 2 cycles, then SHOW 6 cycles with `seg_o`=0x00 and `com_o`=01, alternating with 10. `com_oe_o`=11.
- `load_i` with `value_i`=0x42 mid-frame:
  - Display unchanged until `frame_done_o`.
  - Next frame: digit0 SHOW `seg_o`=0x5B, `com_o`=01; digit1 SHOW `seg_o`=0x66, `com_o`=10.
- `seg_pol_i`=0, `com_pol_i`=0 with 0x42 loaded:
  - digit0 SHOW `seg_o`=0xA4, `com_o`=10.
  - GUARD `seg_o`=0xFF, `com_o`=11.
- Load 0x07:
  - with `SEG_SCAN_LZB_EN`, digit1 `seg_o`=0x00;
  - without it, digit1 `seg_o`=0x3F;
  - digit0 `seg_o`=0x07 in both builds.
- Load 0xFA with `dp_i`=01 → digit0 `seg_o`=0xC0, digit1 `seg_o`=0x00.
- `enable_i` dropped in a SHOW cycle → next cycle `com_oe_o`=00. Re-enable → digit 0 GUARD, no `frame_done_o`. `rst` asserted mid-frame → blank display, `com_oe_o`=00.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: scanner states, seven-segment glyph constants and the BCD glyph lookup.
package seg_scan_pkg;
    typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [9:0][7:0] SEG_DIGITS = {
        8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] nib, input logic dp);
        logic [7:0] g;
        g = nib < 4'd10 ? SEG_DIGITS[nib] : nib == 4'hF ? SEG_BLANK : SEG_DASH;
        return {dp, g[6:0]};
    endfunction
endpackage

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: value/control inputs and pad-side outputs of the scanner.
interface seg_scan_mux_if #(parameter int DIGITS = 2);
    logic                  enable_i;
    logic [4*DIGITS-1:0]   value_i;
    logic [DIGITS-1:0]     dp_i;
    logic                  load_i;
    logic                  seg_pol_i;
    logic                  com_pol_i;
    logic [7:0]            seg_o;
    logic [DIGITS-1:0]     com_o;
    logic [DIGITS-1:0]     com_oe_o;
    logic                  frame_done_o;
    modport master (
        output enable_i, value_i, dp_i, load_i, seg_pol_i, com_pol_i,
        input  seg_o, com_o, com_oe_o, frame_done_o
    );
    modport slave (
        input  enable_i, value_i, dp_i, load_i, seg_pol_i, com_pol_i,
        output seg_o, com_o, com_oe_o, frame_done_o
    );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble plus decimal point to {dp,g..a} glyph.
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);
    assign seg = bcd_to_seg(nib, dp);
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed seven-segment scanner with guard blanking and tear-free buffering.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int DIGITS       = 2,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
)(
    input  logic          clk,
    input  logic          rst,
    seg_scan_mux_if.slave bus
);
    localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    state_t                 state, nxt;
    logic [CW-1:0]          cnt, nc;
    logic [IW-1:0]          idx, ni;
    logic                   bnd;
    logic [DIGITS-1:0][3:0] pend_val, disp_val;
    logic [DIGITS-1:0]      pend_dp, disp_dp;
    logic [DIGITS-1:0]      lz;
    logic [7:0]             glyph, seg_r;
    logic [DIGITS-1:0]      com_r;
    logic                   oe, fd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= nxt;
            cnt   <= nc;
            idx   <= ni;
        end
    end

    always_comb begin
        nxt = state;
        nc  = cnt + 1'b1;
        ni  = idx;
        bnd = 1'b0;
        if (!bus.enable_i) begin
            nxt = IDLE;
            nc  = '0;
            ni  = '0;
        end else if (state == IDLE) begin
            nxt = GUARD;
            nc  = '0;
        end else if (cnt == SLOT_LAST) begin
            nxt = GUARD;
            nc  = '0;
            ni  = idx == IDX_LAST ? '0 : idx + 1'b1;
            bnd = idx == IDX_LAST;
        end else if (state == GUARD && cnt == GUARD_LAST) begin
            nxt = SHOW;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic z;
    // Walk from the leftmost digit; blanking stops at the first nonzero nibble.
    always_comb begin
        lz = '0;
        z  = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            z     = z & (disp_val[k] == 4'd0);
            lz[k] = z;
        end
    end
`else
    assign lz = '0;
`endif

    seg7_decode u_dec (
        .nib (lz[ni] ? 4'hF : disp_val[ni]),
        .dp  (disp_dp[ni]),
        .seg (glyph)
    );

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val <= '1;
            disp_val <= '1;
            pend_dp  <= '0;
            disp_dp  <= '0;
            seg_r    <= '0;
            com_r    <= '0;
            oe       <= 1'b0;
            fd       <= 1'b0;
        end else begin
            seg_r <= nxt == SHOW ? glyph : '0;
            com_r <= nxt == SHOW ? DIGITS'(1) << ni : '0;
            oe    <= nxt != IDLE;
            fd    <= bnd;
            if (bus.load_i) begin
                pend_val <= bus.value_i;
                pend_dp  <= bus.dp_i;
            end
            if (bnd) begin
                disp_val <= bus.load_i ? bus.value_i : pend_val;
                disp_dp  <= bus.load_i ? bus.dp_i : pend_dp;
            end
        end
    end

    assign bus.seg_o        = seg_r ^ {8{~bus.seg_pol_i}};
    assign bus.com_o        = com_r ^ {DIGITS{~bus.com_pol_i}};
    assign bus.com_oe_o     = {DIGITS{oe}};
    assign bus.frame_done_o = fd;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: randomized and directed checks of seg_scan_mux against a slot-time reference model.
module tb_seg_scan_mux;
    localparam int D = 2;
    localparam int P = 8;
    localparam int B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    seg_scan_mux_if #(.DIGITS(D)) bus ();
    seg_scan_mux #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: t counts cycles since scanning started; slot/digit follow by division.
    int           t   = 0;
    logic         act = 1'b0;
    logic         fd  = 1'b0;
    logic [3:0]   pend [D] = '{4'hF, 4'hF};
    logic [3:0]   disp [D] = '{4'hF, 4'hF};
    logic [D-1:0] pdp = '0;
    logic [D-1:0] ddp = '0;

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 8'h3F;  4'd1: return 8'h06;  4'd2: return 8'h5B;
            4'd3: return 8'h4F;  4'd4: return 8'h66;  4'd5: return 8'h6D;
            4'd6: return 8'h7D;  4'd7: return 8'h07;  4'd8: return 8'h7F;
            4'd9: return 8'h6F;  4'd15: return 8'h00;
            default: return 8'h40;
        endcase
    endfunction

    task automatic model_edge();
        if (rst) begin
            act = 1'b0; t = 0; fd = 1'b0; pdp = '0; ddp = '0;
            for (int k = 0; k < D; k++) begin pend[k] = 4'hF; disp[k] = 4'hF; end
        end else begin
            fd = bus.enable_i && act && (t % (D*P) == D*P - 1);
            if (fd) begin
                for (int k = 0; k < D; k++) disp[k] = bus.load_i ? bus.value_i[4*k +: 4] : pend[k];
                ddp = bus.load_i ? bus.dp_i : pdp;
            end
            if (bus.load_i) begin
                for (int k = 0; k < D; k++) pend[k] = bus.value_i[4*k +: 4];
                pdp = bus.dp_i;
            end
            if (!bus.enable_i) begin act = 1'b0; t = 0; end
            else if (!act) begin act = 1'b1; t = 0; end
            else t++;
        end
    endtask

    function automatic logic [12:0] exp_vec();
        logic [7:0]   s = 8'h00;
        logic [7:0]   g;
        logic [D-1:0] c = '0;
        logic [D-1:0] o = '0;
        logic [3:0]   nib;
        int           d;
        logic         z;
        if (act) begin
            o = '1;
            d = (t / P) % D;
            if (t % P >= B) begin
                nib = disp[d];
`ifdef SEG_SCAN_LZB_EN
                z = d > 0;
                for (int k = d; k < D; k++) if (disp[k] != 4'd0) z = 1'b0;
                if (z) nib = 4'hF;
`endif
                g = glyph(nib);
                s = {ddp[d], g[6:0]};
                c = d == 0 ? 2'b01 : 2'b10;
            end
        end
        return {s ^ {8{~bus.seg_pol_i}}, c ^ {D{~bus.com_pol_i}}, o, fd};
    endfunction

    function automatic logic [12:0] cur();
        return {bus.seg_o, bus.com_o, bus.com_oe_o, bus.frame_done_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic seek(input int d, input int pos);
        int n = 0;
        while (!(act && t % P == pos && (t / P) % D == d) && n < 64) begin tick(); n++; end
        if (n >= 64) begin
            checks++; errors++;
            $display("FAIL seek_timeout digit=%0d pos=%0d got no slot within 64 cycles exp reached", d, pos);
        end
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin tick(); n++; end while (!fd && n < 40);
        checks++;
        if (bus.frame_done_o !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_wait got=%b exp=1 after %0d cycles", bus.frame_done_o, n);
        end
    endtask

    task automatic test_reset();
        logic [12:0] got;
        rst = 1'b1;
        tick(); tick();
        got = cur(); checks++;
        if (got !== 13'h0) begin errors++; $display("FAIL reset_state got=%h exp=%h", got, 13'h0); end
        bus.seg_pol_i = 1'b0; bus.com_pol_i = 1'b0;
        #1;
        got = cur(); checks++;
        if (got !== {8'hFF, 2'b11, 2'b00, 1'b0}) begin
            errors++; $display("FAIL reset_inverted got=%h exp=%h", got, {8'hFF, 2'b11, 2'b00, 1'b0});
        end
        bus.seg_pol_i = 1'b1; bus.com_pol_i = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_blank_scan();
        logic [12:0] got, ev;
        bus.enable_i = 1'b1;
        for (int i = 0; i < 2*D*P + 3; i++) begin
            tick();
            got = cur(); ev = exp_vec(); checks++;
            if (got !== ev) begin errors++; $display("FAIL blank_scan t=%0d got=%h exp=%h", t, got, ev); end
        end
        seek(0, B);
        got = cur(); checks++;
        if (got[12:3] !== {8'h00, 2'b01} || got[2:1] !== 2'b11) begin
            errors++; $display("FAIL blank_digit0 got=%h exp seg=00 com=01 oe=11", got);
        end
        seek(1, B);
        got = cur(); checks++;
        if (got[12:3] !== {8'h00, 2'b10}) begin errors++; $display("FAIL blank_digit1 got=%h exp seg=00 com=10", got); end
    endtask

    task automatic test_load_mid_frame();
        logic [12:0] got, ev;
        int n = 0;
        seek(1, 3);
        bus.value_i = 8'h42; bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0;
        while (!fd && n < 40) begin
            got = cur(); ev = exp_vec(); checks++;
            if (got !== ev || got[12:5] !== 8'h00) begin
                errors++; $display("FAIL load_hold t=%0d got=%h exp=%h", t, got, ev);
            end
            tick(); n++;
        end
        seek(0, B);
        got = cur(); checks++;
        if (got[12:3] !== {8'h5B, 2'b01}) begin errors++; $display("FAIL load42_digit0 got=%h exp seg=5b com=01", got); end
        seek(1, B);
        got = cur(); checks++;
        if (got[12:3] !== {8'h66, 2'b10}) begin errors++; $display("FAIL load42_digit1 got=%h exp seg=66 com=10", got); end
    endtask

    task automatic test_polarity();
        logic [12:0] got;
        bus.seg_pol_i = 1'b0; bus.com_pol_i = 1'b0;
        seek(0, B);
        got = cur(); checks++;
        if (got[12:3] !== {8'hA4, 2'b10}) begin errors++; $display("FAIL pol_show got=%h exp seg=a4 com=10", got); end
        seek(1, 0);
        got = cur(); checks++;
        if (got[12:3] !== {8'hFF, 2'b11}) begin errors++; $display("FAIL pol_guard got=%h exp seg=ff com=11", got); end
        bus.seg_pol_i = 1'b1; bus.com_pol_i = 1'b1;
    endtask

    task automatic test_lzb();
        logic [12:0] got;
        logic [7:0]  lead;
`ifdef SEG_SCAN_LZB_EN
        lead = 8'h00;
`else
        lead = 8'h3F;
`endif
        bus.value_i = 8'h07; bus.dp_i = 2'b00; bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0;
        wait_fd();
        seek(0, B);
        got = cur(); checks++;
        if (got[12:5] !== 8'h07) begin errors++; $display("FAIL lzb_digit0 got=%h exp=07", got[12:5]); end
        seek(1, B + 1);
        got = cur(); checks++;
        if (got[12:5] !== lead) begin errors++; $display("FAIL lzb_digit1 got=%h exp=%h", got[12:5], lead); end
        bus.value_i = 8'hFA; bus.dp_i = 2'b01; bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0; bus.dp_i = 2'b00;
        wait_fd();
        seek(0, P - 1);
        got = cur(); checks++;
        if (got[12:5] !== 8'hC0) begin errors++; $display("FAIL dash_dp got=%h exp=c0", got[12:5]); end
        seek(1, B);
        got = cur(); checks++;
        if (got[12:5] !== 8'h00) begin errors++; $display("FAIL blank_glyph got=%h exp=00", got[12:5]); end
    endtask

    task automatic test_enable_drop();
        logic [12:0] got, ev;
        seek(1, 4);
        bus.enable_i = 1'b0;
        tick();
        got = cur(); checks++;
        if (got !== 13'h0) begin errors++; $display("FAIL disable_idle got=%h exp=%h", got, 13'h0); end
        tick();
        bus.enable_i = 1'b1;
        tick();
        got = cur(); checks++;
        if (got !== {8'h00, 2'b00, 2'b11, 1'b0}) begin
            errors++; $display("FAIL reenable_guard got=%h exp=%h", got, {8'h00, 2'b00, 2'b11, 1'b0});
        end
        for (int i = 1; i < D*P; i++) begin
            tick();
            got = cur(); ev = exp_vec(); checks++;
            if (got !== ev || bus.frame_done_o !== 1'b0) begin
                errors++; $display("FAIL reenable_frame t=%0d got=%h exp=%h", t, got, ev);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [12:0] got;
        bus.value_i = 8'h99; bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0;
        wait_fd();
        seek(0, B + 1);
        got = cur(); checks++;
        if (got[12:3] !== {8'h6F, 2'b01}) begin errors++; $display("FAIL nine_show got=%h exp seg=6f com=01", got); end
        bus.value_i = 8'h33; bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0;
        rst = 1'b1;
        tick();
        got = cur(); checks++;
        if (got !== 13'h0) begin errors++; $display("FAIL reset_mid got=%h exp=%h", got, 13'h0); end
        rst = 1'b0;
        seek(0, B);
        wait_fd();
        seek(1, B);
        got = cur(); checks++;
        if (got[12:3] !== {8'h00, 2'b10}) begin errors++; $display("FAIL reset_lost_pending got=%h exp seg=00 com=10", got); end
    endtask

    task automatic test_random();
        logic [12:0] got, ev;
        for (int i = 0; i < 1500; i++) begin
            bus.load_i  = $urandom_range(0, 7) == 0;
            bus.value_i = 8'($urandom);
            bus.dp_i    = 2'($urandom);
            if ($urandom_range(0, 59) == 0) bus.enable_i = ~bus.enable_i;
            if (!bus.enable_i && $urandom_range(0, 3) == 0) bus.enable_i = 1'b1;
            if ($urandom_range(0, 99) == 0) begin bus.seg_pol_i = 1'($urandom); bus.com_pol_i = 1'($urandom); end
            rst = $urandom_range(0, 299) == 0;
            tick();
            got = cur(); ev = exp_vec(); checks++;
            if (got !== ev) begin errors++; $display("FAIL random i=%0d t=%0d got=%h exp=%h", i, t, got, ev); end
        end
        rst = 1'b0; bus.load_i = 1'b0;
    endtask

    initial begin
        bus.enable_i = 1'b0; bus.value_i = '0; bus.dp_i = '0; bus.load_i = 1'b0;
        bus.seg_pol_i = 1'b1; bus.com_pol_i = 1'b1;
        test_reset();
        test_blank_scan();
        test_load_mid_frame();
        test_polarity();
        test_lzb();
        test_enable_drop();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
